// File: rtl/fetch_unit.sv
// Instruction fetch: one-outstanding-request memory front end feeding a small
// in-order instruction queue, with redirect (flush) and halt handling.

module fetch_q_slot #(
  parameter int W = 64
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  q <= '0;
    else if (en)   q <= d;
  end
endmodule

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ctrlFetch,
  input  logic [31:0] newPC,
  input  logic        halt,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic        flush
);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } q_entry_t;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t                  state, state_nxt;
  logic [31:0]             shadow_addr;
  logic [CW-1:0]           count, wr_idx;
  logic                    push, pop, grant;
  q_entry_t                push_ent;
  q_entry_t [DEPTH-1:0]    slot_q, slot_d;
  logic     [DEPTH-1:0]    slot_en;
  logic                    unused_newpc_lsb;

  assign unused_newpc_lsb = ^newPC[1:0];

  // Queue count never includes the outstanding request: requests only issue
  // from IDLE, so count < DEPTH there leaves room for the response.
  assign mem_req     = reset_n && (state == IDLE) && !halt && !ctrlFetch && (count < DEPTH_C);
  assign mem_addr    = pc;
  assign grant       = mem_req && mem_gnt;
  assign instr_valid = (count != '0) && !halt;
  assign pop         = instr_valid && instr_ready;
  assign push        = (state == WAIT) && mem_rvalid && !ctrlFetch;
  assign push_ent    = '{instr: mem_rdata, addr: shadow_addr};
  assign wr_idx      = pop ? count - 1'b1 : count;
  assign instr       = slot_q[0].instr;
  assign instr_pc    = slot_q[0].addr;

  // Shift queue: head lives in slot 0, a pop moves every slot down by one.
  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic hit;
    assign hit        = push && (wr_idx == CW'(i));
    assign slot_en[i] = !ctrlFetch && (pop || hit);
    if (i < DEPTH - 1) begin : g_mid
      assign slot_d[i] = hit ? push_ent : slot_q[i+1];
    end else begin : g_last
      assign slot_d[i] = hit ? push_ent : slot_q[i];
    end
    fetch_q_slot #(.W($bits(q_entry_t))) u_slot (
      .clock   (clock),
      .reset_n (reset_n),
      .en      (slot_en[i]),
      .d       (slot_d[i]),
      .q       (slot_q[i])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (ctrlFetch) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = WAIT;
      WAIT: begin
        if (mem_rvalid)     state_nxt = IDLE;
        else if (ctrlFetch) state_nxt = DROP;
      end
      DROP: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      shadow_addr <= '0;
      flush       <= 1'b0;
    end else begin
      state <= state_nxt;
      flush <= ctrlFetch;
      if (grant) shadow_addr <= pc;
      if (ctrlFetch)  pc <= {newPC[31:2], 2'b00};
      else if (grant) pc <= pc + 32'd4;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized + directed bench for fetch_unit against a queue-based reference model.

module tb_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 3;

  logic        clock = 1'b0, reset_n = 1'b0;
  logic        ctrlFetch = 1'b0, halt = 1'b0, instr_ready = 1'b0;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] newPC = '0, mem_rdata = '0;
  logic        mem_req, instr_valid, flush;
  logic [31:0] mem_addr, instr, instr_pc, pc;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset_n(reset_n), .ctrlFetch(ctrlFetch), .newPC(newPC),
    .halt(halt), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .pc(pc),
    .flush(flush)
  );

  typedef struct { logic [31:0] ins; logic [31:0] a; } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc = RESET_PC, m_oaddr = '0;
  bit          m_out = 0, m_keep = 0, m_flush = 0, stale_rv = 0, addr_data = 1;
  int          rv_cnt = 0, lat_min = 1, lat_max = 1, gnt_pct = 100;
  int          n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return addr_data ? a : (a ^ 32'h5A5A_5A5A);
  endfunction

  task automatic mreset();
    mq.delete();
    m_pc = RESET_PC; m_out = 0; m_keep = 0; m_flush = 0; rv_cnt = 0;
  endtask

  task automatic chk_reset_vals();
    check("rst_pc",          pc,                 RESET_PC);
    check("rst_mem_req",     32'(mem_req),       32'd0);
    check("rst_instr_valid", 32'(instr_valid),   32'd0);
    check("rst_flush",       32'(flush),         32'd0);
    check("rst_instr",       instr,              32'd0);
    check("rst_instr_pc",    instr_pc,           32'd0);
  endtask

  // One clock cycle: drive inputs, compare outputs to the model, advance model.
  task automatic cyc(input bit c, input logic [31:0] np, input bit h, input bit rdy);
    bit e_req, e_vld, gnt, rv, pop;
    logic [31:0] rd;
    @(negedge clock);
    e_req = !m_out && !h && !c && (mq.size() < DEPTH);
    e_vld = (mq.size() > 0) && !h;
    gnt   = e_req && ($urandom_range(0, 99) < gnt_pct);
    rv    = (m_out && rv_cnt == 0) || stale_rv;
    rd    = rdata_of(m_oaddr);
    ctrlFetch = c; newPC = np; halt = h; instr_ready = rdy;
    mem_gnt = gnt; mem_rvalid = rv; mem_rdata = rd;
    stale_rv = 0;
    #1;
    check("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) check("mem_addr", mem_addr, m_pc);
    check("pc", pc, m_pc);
    check("flush", 32'(flush), 32'(m_flush));
    check("instr_valid", 32'(instr_valid), 32'(e_vld));
    if (e_vld) begin
      check("instr", instr, mq[0].ins);
      check("instr_pc", instr_pc, mq[0].a);
    end
    @(posedge clock);
    pop = e_vld && rdy;
    if (pop) void'(mq.pop_front());
    if (rv && m_out) begin
      if (m_keep && !c) mq.push_back('{rd, m_oaddr});
      m_out = 0;
    end else if (m_out && rv_cnt > 0) begin
      rv_cnt--;
    end
    if (c) begin
      mq.delete();
      m_pc   = {np[31:2], 2'b00};
      m_keep = 0;
    end else if (gnt) begin
      m_out   = 1;
      m_keep  = 1;
      m_oaddr = m_pc;
      m_pc    = m_pc + 32'd4;
      rv_cnt  = $urandom_range(lat_min, lat_max) - 1;
    end
    m_flush = c;
  endtask

  task automatic run_until_out(input int max);
    int n = 0;
    while (!m_out && n < max) begin
      cyc(0, '0, 0, 1);
      n++;
    end
    check("gnt_wait", 32'(m_out), 32'd1);
  endtask

  task automatic async_reset();
    @(negedge clock);
    #2;
    ctrlFetch = 0; halt = 0; mem_gnt = 0; mem_rvalid = 0;
    reset_n = 0;
    #1;
    chk_reset_vals();
    mreset();
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state
    #3;
    chk_reset_vals();
    mreset();
    @(negedge clock);
    reset_n = 1;

    // zero-wait memory returning address as data, decode always ready
    addr_data = 1; lat_min = 1; lat_max = 1; gnt_pct = 100;
    repeat (20) cyc(0, '0, 0, 1);

    // decode stalled: queue fills to DEPTH, then drains in order
    repeat (10) cyc(0, '0, 0, 0);
    repeat (12) cyc(0, '0, 0, 1);

    // redirect while a slow request is outstanding
    lat_min = 3; lat_max = 3;
    run_until_out(20);
    cyc(1, 32'h0000_0100, 0, 1);
    repeat (12) cyc(0, '0, 0, 1);

    // halt with one outstanding request
    run_until_out(20);
    repeat (5) cyc(0, '0, 1, 1);
    repeat (10) cyc(0, '0, 0, 1);

    // pc wrap and redirect alignment
    lat_min = 1; lat_max = 1;
    cyc(1, 32'hFFFF_FFFC, 0, 1);
    repeat (6) cyc(0, '0, 0, 1);
    cyc(1, 32'h0000_0103, 0, 1);
    repeat (6) cyc(0, '0, 0, 1);

    // asynchronous reset mid-WAIT; stale response must be ignored
    lat_min = 3; lat_max = 3;
    run_until_out(20);
    async_reset();
    stale_rv = 1;
    repeat (10) cyc(0, '0, 0, 1);

    // random traffic
    addr_data = 0; lat_min = 1; lat_max = 3; gnt_pct = 60;
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 99) < 4, $urandom, $urandom_range(0, 99) < 10,
          $urandom_range(0, 99) < 70);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
